// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the fetch/pc path.
// FSM state encoding and branch funct3 codes.
package cpu_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FETCH = 2'b01,
      S_EXEC  = 2'b10,
      S_HALT  = 2'b11
   } pc_state_t;

   localparam logic [2:0] BT_BEQ  = 3'b000;
   localparam logic [2:0] BT_BNE  = 3'b001;
   localparam logic [2:0] BT_BLT  = 3'b100;
   localparam logic [2:0] BT_BGE  = 3'b101;
   localparam logic [2:0] BT_BLTU = 3'b110;
   localparam logic [2:0] BT_BGEU = 3'b111;

endpackage

// File: rtl/pc_unit_branch_cond.sv
// branch_cond: branch taken decode.
// Flags arrive already resolved from execute.
module branch_cond
   import cpu_pkg::*;
(
   input  logic       Branch,
   input  logic [2:0] BranchType,
   input  logic       zero,
   input  logic       less,
   output logic       taken
);

   // pick the flag that matches funct3; 010/011 never taken
   always_comb begin
      taken = 1'b0;
      unique case (BranchType)
         BT_BEQ, BT_BNE:   taken = Branch & zero;
         BT_BLT, BT_BGE,
         BT_BLTU, BT_BGEU: taken = Branch & less;
         default:          taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter and fetch/exec sequencer.
// Registered outputs; synchronous active-high reset.
module pc_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          IMEM_TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ALUResult,
   input  logic        zero,
   input  logic        less,
   input  logic [31:0] imm32,
   input  logic        Branch,
   input  logic [2:0]  BranchType,
   input  logic        Jump,
   input  logic        Jal,
   input  logic        stall,
   input  logic        halt_req,
   input  logic        imem_ready,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        imem_req,
   output logic        inst_valid,
   output logic        halted,
   output logic        err
);

   localparam int CW = $clog2(IMEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(IMEM_TIMEOUT - 1);

   pc_state_t   state;
   logic [CW-1:0] cnt;
   logic        taken;
   logic [31:0] pc_imm;
   logic [31:0] next_pc;

   branch_cond u_bc (
      .Branch     (Branch),
      .BranchType (BranchType),
      .zero       (zero),
      .less       (less),
      .taken      (taken)
   );

   assign pc_plus4 = pc + 32'd4;
   assign pc_imm   = pc + imm32;

   // next-pc select: jalr over jal over taken branch over fallthrough
   always_comb begin
      next_pc = pc_plus4;
      if (Jump)
         next_pc = ALUResult;
      else if (Jal)
         next_pc = pc_imm;
      else if (taken)
         next_pc = pc_imm;
   end

   // sequencer: fetch handshake, exec commit, halt/error trap
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         cnt        <= '0;
         err        <= 1'b0;
         halted     <= 1'b0;
         imem_req   <= 1'b0;
         inst_valid <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               state    <= S_FETCH;
               imem_req <= 1'b1;
               cnt      <= '0;
            end
            S_FETCH: begin
               if (imem_ready) begin
                  state      <= S_EXEC;
                  imem_req   <= 1'b0;
                  inst_valid <= 1'b1;
                  cnt        <= '0;
               end else if (cnt == LAST) begin
                  state    <= S_HALT;
                  imem_req <= 1'b0;
                  err      <= 1'b1;
                  halted   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_EXEC: begin
               if (!stall) begin
                  inst_valid <= 1'b0;
                  if (halt_req) begin
                     state  <= S_HALT;
                     halted <= 1'b1;
                  end else if (next_pc[1:0] != 2'b00) begin
                     state  <= S_HALT;
                     halted <= 1'b1;
                     err    <= 1'b1;
                  end else begin
                     state    <= S_FETCH;
                     pc       <= next_pc;
                     imem_req <= 1'b1;
                  end
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
